// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: shares one BRAM port between two Wishbone pipelined
// masters (A, B). Ownership is held for a whole bus cycle (CYC lock).
// One access per clock is issued, and ACK returns with a fixed 2-clock latency.
//
// Parameters:
//   DATA_WIDTH - data width of both masters and the BRAM port
//   ADDR_WIDTH - word address width (BRAM depth 1<<ADDR_WIDTH)
// Ports:
//   i_clk, i_rst_n                  - clock, async active-low reset
//   i_x_cyc/stb/we/addr/data        - master x request (x = a, b)
//   o_x_stall/ack/data              - master x response
//   o_bram_en/we/addr/din           - registered BRAM port command
//   i_bram_dout                     - BRAM read data (1-cycle latency)
// Build option:
//   WB_BRAM_ARBITER_ROUND_ROBIN_EN  - if defined, an IDLE tie goes to the
//                                     master that did not own last;
//                                     otherwise A always wins a tie.
module wb_bram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_a_cyc,
    input  logic                  i_a_stb,
    input  logic                  i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    output logic                  o_a_stall,
    output logic                  o_a_ack,
    output logic [DATA_WIDTH-1:0] o_a_data,
    input  logic                  i_b_cyc,
    input  logic                  i_b_stb,
    input  logic                  i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_b_stall,
    output logic                  o_b_ack,
    output logic [DATA_WIDTH-1:0] o_b_data,
    output logic                  o_bram_en,
    output logic                  o_bram_we,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_din,
    input  logic [DATA_WIDTH-1:0] i_bram_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    state_e state_q, state_d;

    // p0: access presented to the BRAM this cycle; p1: ack cycle.
    // *_own: 1 = issued by master B.
    logic p0_q, p0_d, p0_own_q, p0_own_d;
    logic p1_q, p1_d, p1_own_q, p1_own_d;

    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic acc_a, acc_b, busy, tie_b;

`ifdef WB_BRAM_ARBITER_ROUND_ROBIN_EN
    // 1 = B was the last owner
    logic last_q, last_d;
`endif

    always_comb begin
        acc_a   = (state_q == OWN_A) && i_a_cyc && i_a_stb;
        acc_b   = (state_q == OWN_B) && i_b_cyc && i_b_stb;
        busy    = p0_q || p1_q;
        state_d = state_q;
`ifdef WB_BRAM_ARBITER_ROUND_ROBIN_EN
        last_d  = last_q;
        tie_b   = !last_q;
`else
        tie_b   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_a_cyc && i_b_cyc)
                    state_d = tie_b ? OWN_B : OWN_A;
                else if (i_a_cyc)
                    state_d = OWN_A;
                else if (i_b_cyc)
                    state_d = OWN_B;
            end
            OWN_A: begin
                // hold the grant until aborted accesses have drained
                if (!i_a_cyc && !busy) begin
                    state_d = i_b_cyc ? OWN_B : IDLE;
`ifdef WB_BRAM_ARBITER_ROUND_ROBIN_EN
                    last_d  = 1'b0;
`endif
                end
            end
            OWN_B: begin
                if (!i_b_cyc && !busy) begin
                    state_d = i_a_cyc ? OWN_A : IDLE;
`ifdef WB_BRAM_ARBITER_ROUND_ROBIN_EN
                    last_d  = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        p0_d     = acc_a || acc_b;
        p0_own_d = acc_b;
        p1_d     = p0_q;
        p1_own_d = p0_own_q;

        en_d   = acc_a || acc_b;
        we_d   = 1'b0;
        addr_d = addr_q;
        din_d  = din_q;
        if (acc_a) begin
            we_d   = i_a_we;
            addr_d = i_a_addr;
            din_d  = i_a_data;
        end else if (acc_b) begin
            we_d   = i_b_we;
            addr_d = i_b_addr;
            din_d  = i_b_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            p0_q     <= 1'b0;
            p0_own_q <= 1'b0;
            p1_q     <= 1'b0;
            p1_own_q <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            state_q  <= state_d;
            p0_q     <= p0_d;
            p0_own_q <= p0_own_d;
            p1_q     <= p1_d;
            p1_own_q <= p1_own_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
        end
    end

`ifdef WB_BRAM_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end
`endif

    assign o_a_stall   = (state_q != OWN_A);
    assign o_b_stall   = (state_q != OWN_B);
    // an issuer that dropped cyc never sees its pending acks
    assign o_a_ack     = p1_q && !p1_own_q && i_a_cyc;
    assign o_b_ack     = p1_q && p1_own_q && i_b_cyc;
    assign o_a_data    = i_bram_dout;
    assign o_b_data    = i_bram_dout;
    assign o_bram_en   = en_q;
    assign o_bram_we   = we_q;
    assign o_bram_addr = addr_q;
    assign o_bram_din  = din_q;

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Scoreboard bench for wb_bram_arbiter with a write-first BRAM model.
// Drivers push expected acks; a negedge monitor pops and compares.
module tb_wb_bram_arbiter;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk, rst_n;
    logic          a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_stall, a_ack, b_stall, b_ack;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          bram_en, bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din, bram_dout;

    wb_bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_cyc(a_cyc), .i_a_stb(a_stb), .i_a_we(a_we),
        .i_a_addr(a_addr), .i_a_data(a_wdata),
        .o_a_stall(a_stall), .o_a_ack(a_ack), .o_a_data(a_rdata),
        .i_b_cyc(b_cyc), .i_b_stb(b_stb), .i_b_we(b_we),
        .i_b_addr(b_addr), .i_b_data(b_wdata),
        .o_b_stall(b_stall), .o_b_ack(b_ack), .o_b_data(b_rdata),
        .o_bram_en(bram_en), .o_bram_we(bram_we),
        .o_bram_addr(bram_addr), .o_bram_din(bram_din),
        .i_bram_dout(bram_dout)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr] <= bram_din;
                bram_dout      <= bram_din;
            end else begin
                bram_dout <= mem[bram_addr];
            end
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    typedef struct {
        logic          rd;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    bit   gq[$];
    bit   log_grant = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic mon(input bit m);
        bit            exp_ack;
        logic          ack;
        logic [DW-1:0] d;
        exp_t          e;
        if (m) begin
            exp_ack = qb.size() > 0 && qb[0].cyc + 1 == cnt;
            ack = b_ack;
            d = b_rdata;
            chk("b_ack", ack, exp_ack);
            if (exp_ack) begin
                e = qb.pop_front();
                if (e.rd) chk("b_rdata", d, e.data);
            end
        end else begin
            exp_ack = qa.size() > 0 && qa[0].cyc + 1 == cnt;
            ack = a_ack;
            d = a_rdata;
            chk("a_ack", ack, exp_ack);
            if (exp_ack) begin
                e = qa.pop_front();
                if (e.rd) chk("a_rdata", d, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1'b0);
            mon(1'b1);
        end
    end

    task automatic drv(input bit m, input logic cyc, input logic stb,
                       input logic we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d);
        if (m) begin
            b_cyc = cyc; b_stb = stb; b_we = we;
            b_addr = ad; b_wdata = d;
        end else begin
            a_cyc = cyc; a_stb = stb; a_we = we;
            a_addr = ad; a_wdata = d;
        end
    endtask

    task automatic cw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one request; returns at posedge+1 after it is accepted.
    task automatic req(input bit m, input logic we,
                       input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rexp, input bit push);
        bit   ok;
        bit   st;
        exp_t e;
        ok = 1'b0;
        drv(m, 1'b1, 1'b1, we, ad, wd);
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            st = m ? b_stall : a_stall;
            @(posedge clk);
            #1;
            if (!st) begin
                ok = 1'b1;
                if (push) begin
                    e.rd = !we;
                    e.data = rexp;
                    e.cyc = cnt;
                    if (m) qb.push_back(e);
                    else qa.push_back(e);
                end
                if (log_grant) gq.push_back(m);
            end
        end
        chk("req_accept", ok, 1'b1);
    endtask

    task automatic finish_cyc(input bit m);
        drv(m, 1'b1, 1'b0, 1'b0, '0, '0);
        cw(3);
        drv(m, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic round(input bit m, input int r);
        logic [AW-1:0] ad;
        ad = 10'h20 + AW'(r * 2) + AW'(m);
        req(m, 1'b1, ad, 32'h100 + DW'(r), '0, 1'b1);
        finish_cyc(m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit granted;
        rst_n = 1'b1;
        drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        cw(2);
        chk("rst_a_stall", a_stall, 1'b1);
        chk("rst_b_stall", b_stall, 1'b1);
        chk("rst_a_ack", a_ack, 1'b0);
        chk("rst_b_ack", b_ack, 1'b0);
        chk("rst_en", bram_en, 1'b0);
        chk("rst_we", bram_we, 1'b0);
        chk("rst_addr", bram_addr, 10'h000);
        chk("rst_din", bram_din, 32'h0);
        rst_n = 1'b1;
        cw(2);

        // single write then read-back
        req(1'b0, 1'b1, 10'h005, 32'hDEADBEEF, '0, 1'b1);
        req(1'b0, 1'b0, 10'h005, '0, 32'hDEADBEEF, 1'b1);
        finish_cyc(1'b0);
        cw(2);

        // streamed writes then reads
        for (int i = 0; i < 4; i++)
            req(1'b0, 1'b1, 10'h010 + AW'(i), DW'(i + 1), '0, 1'b1);
        for (int i = 0; i < 4; i++)
            req(1'b0, 1'b0, 10'h010 + AW'(i), '0, DW'(i + 1), 1'b1);
        finish_cyc(1'b0);
        cw(2);

        // simultaneous requests, three rounds
        log_grant = 1'b1;
        for (int r = 0; r < 3; r++) begin
            fork
                round(1'b0, r);
                round(1'b1, r);
            join
            cw(3);
        end
        log_grant = 1'b0;
        chk("grant_count", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++)
            chk("grant_order", gq[i], (i % 2) != 0);

        // B holds the bus, A must wait
        req(1'b1, 1'b1, 10'h3FF, 32'hCAFEF00D, '0, 1'b1);
        drv(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        cw(1);
        drv(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("a_stall_while_b", a_stall, 1'b1);
        end
        @(posedge clk);
        #1;
        drv(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        req(1'b0, 1'b0, 10'h3FF, '0, 32'hCAFEF00D, 1'b1);
        finish_cyc(1'b0);
        cw(2);

        // A aborts a read; B is granted only after the drain
        req(1'b0, 1'b0, 10'h005, '0, '0, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        drv(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("b_stall_drain0", b_stall, 1'b1);
        @(negedge clk);
        chk("b_stall_drain1", b_stall, 1'b1);
        granted = 1'b0;
        for (int k = 0; k < 6 && !granted; k++) begin
            @(negedge clk);
            granted = !b_stall;
        end
        chk("b_grant_after_drain", granted, 1'b1);
        @(posedge clk);
        #1;
        req(1'b1, 1'b0, 10'h005, '0, 32'hDEADBEEF, 1'b1);
        finish_cyc(1'b1);
        cw(2);

        // reset while a write is in flight
        req(1'b0, 1'b1, 10'h040, 32'h55, '0, 1'b1);
        cw(1);
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk("midrst_a_ack", a_ack, 1'b0);
        chk("midrst_b_ack", b_ack, 1'b0);
        chk("midrst_en", bram_en, 1'b0);
        chk("midrst_we", bram_we, 1'b0);
        drv(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        cw(2);
        rst_n = 1'b1;
        cw(4);
        chk("post_rst_a_stall", a_stall, 1'b1);
        chk("post_rst_b_stall", b_stall, 1'b1);
        chk("post_rst_en", bram_en, 1'b0);
        cw(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
